// File: rtl/load_store_unit_if.sv
// Single-master Wishbone-style data bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_bus_cyc;
    logic                  o_bus_stb;
    logic                  o_bus_we;
    logic [3:0]            o_bus_sel;
    logic [DATA_WIDTH-1:0] o_bus_adr;
    logic [DATA_WIDTH-1:0] o_bus_dat;
    logic [DATA_WIDTH-1:0] i_bus_dat;
    logic                  i_bus_ack;

    modport master (
        output o_bus_cyc, o_bus_stb, o_bus_we, o_bus_sel, o_bus_adr, o_bus_dat,
        input  i_bus_dat, i_bus_ack
    );

    modport slave (
        input  o_bus_cyc, o_bus_stb, o_bus_we, o_bus_sel, o_bus_adr, o_bus_dat,
        output i_bus_dat, i_bus_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one load/store becomes one bus transaction, with stall and timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses without a bus cycle.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_read_M,
    input  logic                  i_mem_write_M,
    input  logic [2:0]            i_funct3_M,
    input  logic [DATA_WIDTH-1:0] i_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    output logic                  o_stall_M,
    output logic                  o_bus_err,
    output logic                  o_misaligned,
    load_store_unit_if.master     bus
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  BUS     = 2'd1;
    localparam logic [1:0]  DONE    = 2'd2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic                  r_err;
    logic [15:0]           r_cnt;

    logic                  w_req;
    logic                  w_start;
    logic                  w_in_bus;
    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_misaligned;
    logic                  w_rd_update;
    logic [3:0]            w_sel;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic [DATA_WIDTH-1:0] w_load;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_req     = i_mem_read_M | i_mem_write_M;
    assign w_start   = (r_state == IDLE) & w_req;
    assign w_in_bus  = (r_state == BUS);
    assign w_ack     = w_in_bus & bus.i_bus_ack;
    assign w_timeout = w_in_bus & ~bus.i_bus_ack & (r_cnt == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;

    always_comb begin
        case (i_funct3_M[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = i_addr_M[0];
            default: w_misaligned = |i_addr_M[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_start & w_misaligned;
        end
    end

    assign o_misaligned = r_misaligned;
`else
    assign w_misaligned = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_next_state = w_misaligned ? DONE : BUS;
            BUS:     if (bus.i_bus_ack || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Lane selection and write replication; funct3[1:0] alone encodes the access size.
    always_comb begin
        w_sel  = 4'b1111;
        w_wdat = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_sel  = 4'b0001 << r_addr[1:0];
                w_wdat = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_sel  = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = bus.i_bus_dat[7:0];
            2'd1:    w_byte = bus.i_bus_dat[15:8];
            2'd2:    w_byte = bus.i_bus_dat[23:16];
            default: w_byte = bus.i_bus_dat[31:24];
        endcase
        w_half = r_addr[1] ? bus.i_bus_dat[31:16] : bus.i_bus_dat[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'b0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'b0, w_half};
            default: w_load = bus.i_bus_dat;
        endcase
    end

    // Load data changes only when a load completes; aborted or trapped loads return zero.
    assign w_rd_update = (w_in_bus & (bus.i_bus_ack | w_timeout) & ~r_we) |
                         (w_start & w_misaligned & ~i_mem_write_M);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_we        <= 1'b0;
            r_cnt       <= 16'd0;
            r_err       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_timeout;
            if (w_start) begin
                r_addr   <= i_addr_M;
                r_wdata  <= i_write_data_M;
                r_funct3 <= i_funct3_M;
                r_we     <= i_mem_write_M;
                r_cnt    <= 16'd0;
            end else if (w_in_bus && !bus.i_bus_ack) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_rd_update) begin
                r_read_data <= w_ack ? w_load : '0;
            end
        end
    end

    assign bus.o_bus_cyc = w_in_bus;
    assign bus.o_bus_stb = w_in_bus;
    assign bus.o_bus_we  = w_in_bus & r_we;
    assign bus.o_bus_sel = w_in_bus ? w_sel : 4'b0000;
    assign bus.o_bus_adr = w_in_bus ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign bus.o_bus_dat = w_in_bus ? w_wdat : '0;

    assign o_stall_M     = w_start | w_in_bus;
    assign o_bus_err     = r_err;
    assign o_read_data_M = r_read_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses against a behavioural model.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        i_mem_read_M;
    logic        i_mem_write_M;
    logic [2:0]  i_funct3_M;
    logic [31:0] i_addr_M;
    logic [31:0] i_write_data_M;
    logic [31:0] o_read_data_M;
    logic        o_stall_M;
    logic        o_bus_err;
    logic        o_misaligned;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_rd;

    load_store_unit_if #(.DATA_WIDTH(32)) bus_if ();

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_read_M   (i_mem_read_M),
        .i_mem_write_M  (i_mem_write_M),
        .i_funct3_M     (i_funct3_M),
        .i_addr_M       (i_addr_M),
        .i_write_data_M (i_write_data_M),
        .o_read_data_M  (o_read_data_M),
        .o_stall_M      (o_stall_M),
        .o_bus_err      (o_bus_err),
        .o_misaligned   (o_misaligned),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] f3, input logic [31:0] a);
        int n = ref_size(f3);
        if (n == 1) return 4'(1 << (a % 4));
        if (n == 2) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_dat(input logic [2:0] f3, input logic [31:0] wd);
        int n = ref_size(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        int          n = ref_size(f3);
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (n == 4) return d;
        sh   = (n == 1) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v    = (d >> sh) & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % ref_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge with the DUT idle; ack_at=0 or >TO means the slave never acknowledges.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] rdata);
        logic mis;
        logic t_out;
        int   n_stb;
        mis   = ref_mis(f3, addr);
        t_out = !mis && !(ack_at >= 1 && ack_at <= TO);
        n_stb = mis ? 0 : (t_out ? TO : ack_at);

        bus_if.i_bus_ack = 1'b0;
        i_mem_read_M     = rd;
        i_mem_write_M    = wr;
        i_funct3_M       = f3;
        i_addr_M         = addr;
        i_write_data_M   = wdata;
        #1;
        check_eq("stall_req", 32'(o_stall_M), 32'd1);
        @(negedge clk);
        for (int c = 1; c <= n_stb; c++) begin
            check_eq("cyc", 32'(bus_if.o_bus_cyc), 32'd1);
            check_eq("stb", 32'(bus_if.o_bus_stb), 32'd1);
            check_eq("we", 32'(bus_if.o_bus_we), 32'(wr));
            check_eq("sel", 32'(bus_if.o_bus_sel), 32'(ref_sel(f3, addr)));
            check_eq("adr", bus_if.o_bus_adr, addr & ~32'd3);
            if (wr) check_eq("dat", bus_if.o_bus_dat, ref_dat(f3, wdata));
            check_eq("stall_bus", 32'(o_stall_M), 32'd1);
            bus_if.i_bus_ack = (c == ack_at);
            bus_if.i_bus_dat = (c == ack_at) ? rdata : $urandom;
            @(negedge clk);
        end
        if (!wr) exp_rd = (mis || t_out) ? 32'd0 : ref_load(f3, addr, rdata);
        check_eq("done_cyc", 32'(bus_if.o_bus_cyc), 32'd0);
        check_eq("done_stb", 32'(bus_if.o_bus_stb), 32'd0);
        check_eq("done_stall", 32'(o_stall_M), 32'd0);
        check_eq("done_err", 32'(o_bus_err), 32'(t_out));
        check_eq("done_mis", 32'(o_misaligned), 32'(mis));
        check_eq("done_rdata", o_read_data_M, exp_rd);
        i_mem_read_M     = 1'b0;
        i_mem_write_M    = 1'b0;
        bus_if.i_bus_ack = 1'($urandom_range(0, 1));
        bus_if.i_bus_dat = $urandom;
        @(negedge clk);
        check_eq("idle_err", 32'(o_bus_err), 32'd0);
        check_eq("idle_mis", 32'(o_misaligned), 32'd0);
        check_eq("idle_stb", 32'(bus_if.o_bus_stb), 32'd0);
        check_eq("idle_stall", 32'(o_stall_M), 32'd0);
        check_eq("idle_rdata", o_read_data_M, exp_rd);
        bus_if.i_bus_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [2:0] f3_tab [8];
        int         op;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        n_checks = 0;
        n_errors = 0;
        exp_rd   = 32'd0;
        rst              = 1'b1;
        i_mem_read_M     = 1'b0;
        i_mem_write_M    = 1'b0;
        i_funct3_M       = 3'd0;
        i_addr_M         = 32'd0;
        i_write_data_M   = 32'd0;
        bus_if.i_bus_ack = 1'b0;
        bus_if.i_bus_dat = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_cyc", 32'(bus_if.o_bus_cyc), 32'd0);
        check_eq("rst_stb", 32'(bus_if.o_bus_stb), 32'd0);
        check_eq("rst_we", 32'(bus_if.o_bus_we), 32'd0);
        check_eq("rst_sel", 32'(bus_if.o_bus_sel), 32'd0);
        check_eq("rst_adr", bus_if.o_bus_adr, 32'd0);
        check_eq("rst_dat", bus_if.o_bus_dat, 32'd0);
        check_eq("rst_rdata", o_read_data_M, 32'd0);
        check_eq("rst_err", 32'(o_bus_err), 32'd0);
        check_eq("rst_mis", 32'(o_misaligned), 32'd0);
        check_eq("rst_stall", 32'(o_stall_M), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_access(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        run_access(1'b0, 1'b1, 3'd0, 32'h203, 32'h000000A5, 1, 32'h0);
        run_access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'd0, 32'h301, 32'h0, 1, 32'h1234F600);
        run_access(1'b1, 1'b0, 3'd5, 32'h302, 32'h0, 3, 32'h80010000);
        run_access(1'b1, 1'b0, 3'd2, 32'h402, 32'h0, 1, 32'h55AA1234);
        run_access(1'b1, 1'b1, 3'd1, 32'h506, 32'h0000BEEF, 4, 32'h0);

        // Reset lands on the second bus cycle together with an ack that must be dropped.
        run_access(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 1, 32'h13579BDF);
        i_mem_read_M = 1'b1;
        i_funct3_M   = 3'd2;
        i_addr_M     = 32'h700;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_stb", 32'(bus_if.o_bus_stb), 32'd1);
        rst              = 1'b1;
        i_mem_read_M     = 1'b0;
        bus_if.i_bus_ack = 1'b1;
        bus_if.i_bus_dat = 32'hCAFEBABE;
        @(negedge clk);
        check_eq("mid_rst_cyc", 32'(bus_if.o_bus_cyc), 32'd0);
        check_eq("mid_rst_stb", 32'(bus_if.o_bus_stb), 32'd0);
        check_eq("mid_rst_stall", 32'(o_stall_M), 32'd0);
        check_eq("mid_rst_rdata", o_read_data_M, 32'd0);
        rst              = 1'b0;
        bus_if.i_bus_ack = 1'b0;
        exp_rd           = 32'd0;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 2));
            run_access(1'(op != 1), 1'(op != 0), f3_tab[$urandom_range(0, 7)], $urandom,
                       $urandom, int'($urandom_range(0, 6)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
